// File: rtl/nibble_serial_add_ctrl.sv
// Wide adder built from one 4-bit adder, one nibble per clock, LSB first; sum valid NIB cycles after accept.
// Result is held in DONE until out_ready; operands are only taken in IDLE, so operations never overlap.

module four_bit_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {4'b0000, ci};

endmodule

module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NIB  = WIDTH / 4;
  // A single-nibble build still needs a 1-bit index so the part-select offset is well formed.
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDXW-1:0]  idx;
  logic [IDXW+1:0]  bit_off;
  logic             carry;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [3:0]       nib_sum;
  logic             nib_co;

  assign bit_off = {idx, 2'b00};

  four_bit_adder u_adder (
    .a  (a_reg[bit_off +: 4]),
    .b  (b_reg[bit_off +: 4]),
    .ci (carry),
    .s  (nib_sum),
    .co (nib_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid) state_nxt = ADD;
      ADD:     if (idx == LAST_IDX) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state == ADD) || (state == DONE);
  end

  // Carry is chained nibble to nibble through this register; cout is latched on the last nibble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= b;
            carry <= cin;
            idx   <= '0;
          end
        end
        ADD: begin
          sum[bit_off +: 4] <= nib_sum;
          carry             <= nib_co;
          if (idx == LAST_IDX) begin
            cout <= nib_co;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) idx <= '0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Bench for nibble_serial_add_ctrl: 16-bit and 4-bit instances against arithmetic reference a+b+cin.
module tb_nibble_serial_add_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst16, in_valid16, in_ready16, cin16, out_valid16, out_ready16, cout16, busy16;
  logic [15:0] a16, b16, sum16;
  logic        rst4, in_valid4, in_ready4, cin4, out_valid4, out_ready4, cout4, busy4;
  logic [3:0]  a4, b4, sum4;

  nibble_serial_add_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst16), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .cin(cin16), .out_valid(out_valid16), .out_ready(out_ready16),
    .sum(sum16), .cout(cout16), .busy(busy16)
  );

  nibble_serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst4), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .cout(cout4), .busy(busy4)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        co;
  } vec_t;

  vec_t vecs[7];

  // Called #1 after a rising edge with the 16-bit instance idle and out_ready16 high.
  task automatic run16(input logic [15:0] ta, input logic [15:0] tbv, input logic tc,
                       output logic [15:0] ts, output logic tco, output int lat, output int bcnt);
    int n;
    a16 = ta; b16 = tbv; cin16 = tc; in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    lat = 0;
    bcnt = busy16 ? 1 : 0;
    while (!out_valid16 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (busy16) bcnt++;
    end
    ts = sum16; tco = cout16;
    n = 0;
    while (busy16 && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (busy16) bcnt++;
    end
  endtask

  task automatic run4(input logic [3:0] ta, input logic [3:0] tbv, input logic tc, input int stall,
                      output logic [3:0] ts, output logic tco, output int lat);
    a4 = ta; b4 = tbv; cin4 = tc; in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    lat = 0;
    while (!out_valid4 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    ts = sum4; tco = cout4;
    repeat (stall) begin
      @(posedge clk); #1;
    end
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    out_ready4 = 1'b0;
  endtask

  initial begin
    logic [15:0] s;
    logic        co;
    logic [3:0]  s4;
    logic        co4;
    logic [16:0] q[$];
    logic [16:0] e17;
    logic [4:0]  e5;
    int          lat, bcnt, cyc, n_acc, lat_sum;
    int          acc_cyc[3];
    bit          accepted;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[3] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[5] = '{16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0};
    vecs[6] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0};

    rst16 = 1'b0; rst4 = 1'b0;
    in_valid16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; out_ready16 = 1'b1;
    in_valid4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; out_ready4 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_sum", 32'(sum16), 32'h0);
    chk("rst_cout", 32'(cout16), 32'h0);
    chk("rst_out_valid", 32'(out_valid16), 32'h0);
    chk("rst_in_ready", 32'(in_ready16), 32'h1);
    chk("rst_busy", 32'(busy16), 32'h0);
    chk("rst4_in_ready", 32'(in_ready4), 32'h1);
    rst16 = 1'b1; rst4 = 1'b1;
    @(posedge clk); #1;

    // Directed vector table, out_ready held high.
    for (int i = 0; i < 7; i++) begin
      run16(vecs[i].a, vecs[i].b, vecs[i].cin, s, co, lat, bcnt);
      chk($sformatf("vec%0d_sum", i), 32'(s), 32'(vecs[i].s));
      chk($sformatf("vec%0d_cout", i), 32'(co), 32'(vecs[i].co));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd4);
      chk($sformatf("vec%0d_busy", i), 32'(bcnt), 32'd5);
    end

    // Backpressure: result held, new operands ignored, then simultaneous in_valid/out_ready in DONE.
    out_ready16 = 1'b0;
    a16 = 16'h00F0; b16 = 16'h0F0F; cin16 = 1'b1; in_valid16 = 1'b1;
    @(posedge clk); #1;
    a16 = 16'h0001; b16 = 16'h0001; cin16 = 1'b0;
    lat = 0;
    while (!out_valid16 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_lat", 32'(lat), 32'd4);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d_valid", i), 32'(out_valid16), 32'h1);
      chk($sformatf("bp_hold%0d_sum", i), 32'(sum16), 32'h1000);
      chk($sformatf("bp_hold%0d_cout", i), 32'(cout16), 32'h0);
      chk($sformatf("bp_hold%0d_in_ready", i), 32'(in_ready16), 32'h0);
    end
    out_ready16 = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 32'(out_valid16), 32'h0);
    chk("bp_release_in_ready", 32'(in_ready16), 32'h1);
    chk("bp_idle_sum_kept", 32'(sum16), 32'h1000);
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    chk("bp_next_busy", 32'(busy16), 32'h1);
    lat = 0;
    while (!out_valid16 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_next_sum", 32'(sum16), 32'h0002);
    chk("bp_next_lat", 32'(lat), 32'd4);
    @(posedge clk); #1;

    // Reset two cycles into ADD discards the partial result.
    a16 = 16'h1234; b16 = 16'h0001; cin16 = 1'b0; in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst16 = 1'b0;
    #1;
    chk("midrst_sum", 32'(sum16), 32'h0);
    chk("midrst_cout", 32'(cout16), 32'h0);
    chk("midrst_out_valid", 32'(out_valid16), 32'h0);
    chk("midrst_in_ready", 32'(in_ready16), 32'h1);
    chk("midrst_busy", 32'(busy16), 32'h0);
    @(negedge clk);
    rst16 = 1'b1;
    @(posedge clk); #1;
    run16(16'h00FF, 16'h0001, 1'b0, s, co, lat, bcnt);
    chk("postrst_sum", 32'(s), 32'h0100);
    chk("postrst_cout", 32'(co), 32'h0);

    // Back-to-back random operations with in_valid and out_ready held high.
    n_acc = 0; cyc = 0;
    a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
    in_valid16 = 1'b1; out_ready16 = 1'b1;
    while ((n_acc < 3 || q.size() > 0) && cyc < 200) begin
      if (out_valid16) begin
        if (q.size() == 0) begin
          chk("b2b_unexpected_result", 32'(out_valid16), 32'h0);
        end else begin
          e17 = q.pop_front();
          chk("b2b_sum", 32'(sum16), 32'(e17[15:0]));
          chk("b2b_cout", 32'(cout16), 32'(e17[16]));
        end
      end
      accepted = 1'b0;
      if (in_ready16 && n_acc < 3) begin
        q.push_back(17'(a16) + 17'(b16) + 17'(cin16));
        acc_cyc[n_acc] = cyc;
        n_acc++;
        accepted = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
      if (accepted) begin
        a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
        if (n_acc == 3) in_valid16 = 1'b0;
      end
    end
    chk("b2b_timeout", 32'(cyc < 200), 32'h1);
    chk("b2b_space1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd6);
    chk("b2b_space2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd6);

    // WIDTH=4 instance: directed, then randomized with random result stalls.
    run4(4'h9, 4'h8, 1'b0, 0, s4, co4, lat);
    chk("w4_sum", 32'(s4), 32'h1);
    chk("w4_cout", 32'(co4), 32'h1);
    chk("w4_lat", 32'(lat), 32'd1);
    lat_sum = 0;
    for (int i = 0; i < 200; i++) begin
      logic [3:0] ra, rb;
      logic       rc;
      ra = 4'($urandom); rb = 4'($urandom); rc = 1'($urandom);
      e5 = 5'(ra) + 5'(rb) + 5'(rc);
      run4(ra, rb, rc, int'($urandom_range(0, 2)), s4, co4, lat);
      chk($sformatf("w4_rand%0d_sum", i), 32'(s4), 32'(e5[3:0]));
      chk($sformatf("w4_rand%0d_cout", i), 32'(co4), 32'(e5[4]));
      lat_sum += lat;
    end
    chk("w4_rand_lat_total", 32'(lat_sum), 32'd200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
